// File: rtl/operand_fetch_seq_if.sv
// Bus bundle between the operand fetch sequencer and its environment:
// mux select/data path, operand registers and transaction status.
interface operand_fetch_seq_if #(
  parameter int WIDTH = 8
);
  // Handshake: START is accepted only on an edge where the sequencer is idle
  // (no ready signal, caller watches BUSY/DONE); DONE pulses for one cycle.
  logic             START;
  logic [2:0]       MASK;
  logic [WIDTH-1:0] D;
  logic [1:0]       S;
  logic [WIDTH-1:0] R1;
  logic [WIDTH-1:0] R2;
  logic [WIDTH-1:0] R3;
  logic [2:0]       CAPT;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       DBG_STATE;

  modport master (
    output START, MASK, D,
    input  S, R1, R2, R3, CAPT, BUSY, DONE, DBG_STATE
  );

  modport slave (
    input  START, MASK, D,
    output S, R1, R2, R3, CAPT, BUSY, DONE, DBG_STATE
  );
endinterface

// File: rtl/operand_fetch_seq.sv
// Operand fetch sequencer: steps a 3:1 bus mux through the masked inputs,
// holds each select for SETTLE+1 cycles and latches the bus into R1..R3.
module operand_fetch_seq #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input logic                CLK,
  input logic                RST,
  operand_fetch_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t           r_state;
  logic [2:0]       r_mask;
  logic [3:0]       r_cnt;
  logic [1:0]       r_idx;
  logic [1:0]       r_s;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_r1;
  logic [WIDTH-1:0] r_r2;
  logic [WIDTH-1:0] r_r3;
  logic [2:0]       r_capt;

  logic [2:0]       w_rem;
  logic [1:0]       w_next_idx;
  logic [1:0]       w_start_idx;

  function automatic logic [1:0] low_idx(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  // Mask left after retiring the operand currently on the bus.
  always_comb begin
    w_rem       = r_mask & ~(3'b001 << r_idx);
    w_next_idx  = low_idx(w_rem);
    w_start_idx = low_idx(bus.MASK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_r3    <= '0;
      r_capt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s    <= '0;
          r_busy <= 1'b0;
          if (bus.START) begin
            r_mask <= bus.MASK;
            r_capt <= '0;
            if (bus.MASK == 3'b000) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
              r_idx   <= w_start_idx;
              r_s     <= w_start_idx + 2'd1;
              r_cnt   <= SETTLE_CNT;
              r_busy  <= 1'b1;
            end
          end
        end

        ST_FETCH: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            case (r_idx)
              2'd0:    r_r1 <= bus.D;
              2'd1:    r_r2 <= bus.D;
              default: r_r3 <= bus.D;
            endcase
            r_capt <= r_capt | (3'b001 << r_idx);
            r_mask <= w_rem;
            if (w_rem != 3'b000) begin
              r_idx <= w_next_idx;
              r_s   <= w_next_idx + 2'd1;
              r_cnt <= SETTLE_CNT;
            end else begin
              r_state <= ST_FIN;
              r_s     <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        ST_FIN: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_s     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S         = r_s;
  assign bus.R1        = r_r1;
  assign bus.R2        = r_r2;
  assign bus.R3        = r_r3;
  assign bus.CAPT      = r_capt;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.DBG_STATE = r_state;

endmodule
